// File: rtl/neuro_pkg.sv
// Shared types and widths for the neuron MAC sequencer and its multiplier.
package neuro_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int ACC_A_W = 12;
  localparam int ACC_Y_W = 28;
  localparam int DEF_X_W = 6;
  localparam int DEF_W_W = 6;

endpackage

// File: rtl/mac_mult.sv
// Registered signed multiplier, stage 1 -> 2 of the MAC pipeline.
// The product register is forced to zero whenever the input is not valid.
module mac_mult
  import neuro_pkg::*;
#(
  parameter int A_W = DEF_X_W,
  parameter int B_W = DEF_W_W,
  parameter int P_W = ACC_A_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic signed [A_W-1:0] i_a,
  input  logic signed [B_W-1:0] i_b,
  output logic                  o_valid,
  output logic signed [P_W-1:0] o_p
);

  logic signed [P_W-1:0] w_prod;
  logic signed [P_W-1:0] r_p;
  logic                  r_valid;

  // Both operands are sign-extended to the full product width before multiplying.
  assign w_prod = P_W'(i_a) * P_W'(i_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      r_p     <= i_valid ? w_prod : '0;
    end
  end

  assign o_valid = r_valid;
  assign o_p     = r_p;

endmodule

// File: rtl/neuron_mac_ctrl.sv
// Sequencer that walks one neuron's input/weight memories and streams signed
// products to the downstream accumulator, bracketed by acc_clr and done.
module neuron_mac_ctrl
  import neuro_pkg::*;
#(
  parameter int N_INPUTS  = 16,
  parameter int N_NEURONS = 4,
  parameter int X_W       = DEF_X_W,
  parameter int W_W       = DEF_W_W,
  parameter int XA_W      = $clog2(N_INPUTS),
  parameter int WA_W      = $clog2(N_INPUTS * N_NEURONS),
  parameter int NS_W      = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NS_W-1:0]           neuron_sel,
  output logic                      busy,
  output logic                      done,
  output logic [XA_W-1:0]           x_addr,
  input  logic signed [X_W-1:0]     x_data,
  output logic [WA_W-1:0]           w_addr,
  input  logic signed [W_W-1:0]     w_data,
  output logic                      acc_clr,
  output logic                      acc_ce,
  output logic signed [ACC_A_W-1:0] acc_a
);

  localparam logic [XA_W-1:0] LAST_IDX = XA_W'(N_INPUTS - 1);

  state_t          r_state;
  logic            r_drain_last;
  logic            r_busy;
  logic            r_done;
  logic            r_acc_clr;
  logic            r_v0;
  logic            r_v1;
  logic [XA_W-1:0] r_x_addr;
  logic [WA_W-1:0] r_w_addr;
  logic [WA_W-1:0] w_w_base;

  // Out-of-range selects wrap onto a valid weight set.
  always_comb begin
    w_w_base = WA_W'((32'(neuron_sel) % N_NEURONS) * N_INPUTS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_drain_last <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_acc_clr    <= 1'b0;
      r_v0         <= 1'b0;
      r_x_addr     <= '0;
      r_w_addr     <= '0;
    end else begin
      r_done    <= 1'b0;
      r_acc_clr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= CLEAR;
            r_busy    <= 1'b1;
            r_acc_clr <= 1'b1;
            r_v0      <= 1'b1;
            r_x_addr  <= '0;
            r_w_addr  <= w_w_base;
          end
        end
        CLEAR: begin
          r_state  <= RUN;
          r_x_addr <= r_x_addr + 1'b1;
          r_w_addr <= r_w_addr + 1'b1;
        end
        RUN: begin
          if (r_x_addr == LAST_IDX) begin
            r_state      <= DRAIN;
            r_v0         <= 1'b0;
            r_drain_last <= 1'b0;
          end else begin
            r_x_addr <= r_x_addr + 1'b1;
            r_w_addr <= r_w_addr + 1'b1;
          end
        end
        DRAIN: begin
          // Two drain cycles: one for the memory read, one for the multiplier.
          if (r_drain_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain_last <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory data lags the address by one cycle; track that with its own valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= r_v0;
    end
  end

  mac_mult #(
    .A_W(X_W),
    .B_W(W_W),
    .P_W(ACC_A_W)
  ) u_mult (
    .clk    (clk),
    .rst    (rst),
    .i_valid(r_v1),
    .i_a    (x_data),
    .i_b    (w_data),
    .o_valid(acc_ce),
    .o_p    (acc_a)
  );

  assign busy    = r_busy;
  assign done    = r_done;
  assign acc_clr = r_acc_clr;
  assign x_addr  = r_x_addr;
  assign w_addr  = r_w_addr;

endmodule
